// File: rtl/dcf77_frame_decoder_pkg.sv
// Shared constants, FSM states and frame layout for the DCF77 frame decoder.
package dcf77_frame_decoder_pkg;

  localparam int unsigned FRAME_BITS = 59;
  localparam int unsigned BCNT_W     = 6;
  localparam int unsigned CNT_W      = 8;

  // Bit positions inside the 59-bit DCF77 time code
  localparam int unsigned MIN_LO  = 21;
  localparam int unsigned MIN_P   = 28;
  localparam int unsigned HR_LO   = 29;
  localparam int unsigned HR_P    = 35;
  localparam int unsigned DATE_LO = 36;
  localparam int unsigned DATE_P  = 58;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_GAP   = 2'd1,
    ST_PULSE = 2'd2
  } dcf_state_e;

  // Frame view with DCF bit n at flat index n; each field carries its parity bit as MSB
  typedef struct packed {
    logic [DATE_P-DATE_LO:0] date;
    logic [HR_P-HR_LO:0]     hour;
    logic [MIN_P-MIN_LO:0]   minute;
    logic [MIN_LO-1:0]       head;
  } dcf_frame_t;

  // Content checks of a complete frame (length is checked by the caller)
  function automatic logic frame_fields_ok(dcf_frame_t f);
    logic ok;
    ok = ~f.head[0] & f.head[MIN_LO-1];
    ok = ok & ~(^f.minute) & ~(^f.hour) & ~(^f.date);
    ok = ok & (f.minute[3:0] <= 4'd9) & (f.hour[3:0] <= 4'd9);
    return ok;
  endfunction

endpackage

// File: rtl/dcf77_frame_decoder_pulse_filter.sv
// Input conditioning: 2-FF synchroniser, sample-tick divider and 2-sample debounce.
module dcf77_frame_decoder_pulse_filter #(
  parameter int unsigned TICK_DIV = 250000
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic dcf_in,
  output logic tick,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned       DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [1:0]       sync_q;
  logic [DIV_W-1:0] div_q;
  logic             samp_q;

  // Level changes when this tick's sample and the previous one agree on a new value
  assign rise_c = tick &  sync_q[1] &  samp_q & ~level;
  assign fall_c = tick & ~sync_q[1] & ~samp_q &  level;

  // Bring the asynchronous receiver output into the clk_in domain
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], dcf_in};
    end
  end

  // Free-running divider producing a one-cycle sample tick
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      tick  <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
      tick  <= 1'b1;
    end else begin
      div_q <= div_q + DIV_W'(1);
      tick  <= 1'b0;
    end
  end

  // Debounce: remember the last tick sample and update the filtered level
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      samp_q <= 1'b0;
      level  <= 1'b0;
    end else if (tick) begin
      samp_q <= sync_q[1];
      if (rise_c || fall_c) begin
        level <= sync_q[1];
      end
    end
  end

endmodule

// File: rtl/dcf77_frame_decoder.sv
// DCF77 decoder: measures pulse/gap widths, assembles the minute frame and publishes valid frames.
module dcf77_frame_decoder
  import dcf77_frame_decoder_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 250000,
  parameter int unsigned MIN_PULSE  = 5,
  parameter int unsigned BIT_THRESH = 15,
  parameter int unsigned MAX_PULSE  = 30,
  parameter int unsigned GAP_MARK   = 150,
  parameter int unsigned MAX_GAP    = 210
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  input  logic                  dcf_in,
  output logic [FRAME_BITS-1:0] wb_tempbuffer,
  output logic                  sincro,
  output logic                  locked,
  output logic                  frame_error,
  output logic [BCNT_W-1:0]     bit_count
);

  localparam logic [CNT_W-1:0]  MIN_PULSE_C  = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0]  THRESH_C     = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0]  MAX_PULSE_C  = CNT_W'(MAX_PULSE);
  localparam logic [CNT_W-1:0]  GAP_MARK_C   = CNT_W'(GAP_MARK);
  localparam logic [CNT_W-1:0]  MAX_GAP_C    = CNT_W'(MAX_GAP);
  localparam logic [CNT_W-1:0]  CNT_SAT      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_PRE_SAT  = CNT_SAT - CNT_W'(1);
  localparam logic [BCNT_W-1:0] FRAME_LEN_C  = BCNT_W'(FRAME_BITS);

  logic                  tick;
  logic                  level;
  logic                  rise_c;
  logic                  fall_c;

  logic [CNT_W-1:0]      pulse_cnt;
  logic [CNT_W-1:0]      gap_cnt;

  dcf_state_e            state_q;
  dcf_state_e            state_d;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] shift_d;
  logic [FRAME_BITS-1:0] wb_d;
  logic [BCNT_W-1:0]     bit_count_d;
  logic                  sincro_d;
  logic                  locked_d;
  logic                  error_d;

  logic                  is_mark_c;
  logic                  pulse_ok_c;
  logic                  frame_ok_c;
  logic                  lost_c;
  logic                  stuck_c;

  dcf77_frame_decoder_pulse_filter #(
    .TICK_DIV (TICK_DIV)
  ) u_filter (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .dcf_in  (dcf_in),
    .tick    (tick),
    .level   (level),
    .rise_c  (rise_c),
    .fall_c  (fall_c)
  );

  // Width classification of the phase that is just ending
  assign is_mark_c  = gap_cnt >= GAP_MARK_C;
  assign pulse_ok_c = (pulse_cnt >= MIN_PULSE_C) && (pulse_cnt <= MAX_PULSE_C);
  assign frame_ok_c = (bit_count == FRAME_LEN_C) && frame_fields_ok(dcf_frame_t'(shift_q));
  // One-shot events on the tick where a counter steps past its limit
  assign lost_c     = tick && !level && (gap_cnt == MAX_GAP_C);
  assign stuck_c    = tick && (pulse_cnt == CNT_PRE_SAT);

  // Saturating phase-width counters, each cleared by the edge opening its phase
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      pulse_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      if (rise_c) begin
        pulse_cnt <= '0;
      end else if (tick && (pulse_cnt != CNT_SAT)) begin
        pulse_cnt <= pulse_cnt + CNT_W'(1);
      end
      if (fall_c) begin
        gap_cnt <= '0;
      end else if (tick && (gap_cnt != CNT_SAT)) begin
        gap_cnt <= gap_cnt + CNT_W'(1);
      end
    end
  end

  // State, frame assembly and published outputs
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_HUNT;
      shift_q       <= '0;
      wb_tempbuffer <= '0;
      bit_count     <= '0;
      sincro        <= 1'b0;
      locked        <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      wb_tempbuffer <= wb_d;
      bit_count     <= bit_count_d;
      sincro        <= sincro_d;
      locked        <= locked_d;
      frame_error   <= error_d;
    end
  end

  // Next-state logic: second/minute-mark decoding and frame evaluation
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    wb_d        = wb_tempbuffer;
    bit_count_d = bit_count;
    sincro_d    = 1'b0;
    locked_d    = locked;
    error_d     = 1'b0;

    unique case (state_q)
      ST_HUNT: begin
        if (rise_c) begin
          if (is_mark_c) begin
            state_d     = ST_PULSE;
            bit_count_d = '0;
          end
        end else if (lost_c) begin
          error_d  = 1'b1;
          locked_d = 1'b0;
        end
      end

      ST_GAP: begin
        if (rise_c) begin
          state_d = ST_PULSE;
          if (is_mark_c) begin
            bit_count_d = '0;
            if (frame_ok_c) begin
              wb_d     = shift_q;
              sincro_d = 1'b1;
              locked_d = 1'b1;
            end else begin
              error_d  = 1'b1;
              locked_d = 1'b0;
            end
          end
        end else if (lost_c) begin
          error_d     = 1'b1;
          locked_d    = 1'b0;
          bit_count_d = '0;
          state_d     = ST_HUNT;
        end
      end

      ST_PULSE: begin
        if (fall_c) begin
          if (!pulse_ok_c || (bit_count == FRAME_LEN_C)) begin
            error_d     = 1'b1;
            bit_count_d = '0;
            state_d     = ST_HUNT;
          end else begin
            shift_d[bit_count] = (pulse_cnt >= THRESH_C);
            bit_count_d        = bit_count + BCNT_W'(1);
            state_d            = ST_GAP;
          end
        end else if (stuck_c) begin
          error_d     = 1'b1;
          bit_count_d = '0;
          state_d     = ST_HUNT;
        end
      end

      default: begin
        state_d     = ST_HUNT;
        bit_count_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_dcf77_frame_decoder.sv
// Randomized self-checking bench for dcf77_frame_decoder with a field-level frame model.
module tb_dcf77_frame_decoder;

  localparam int unsigned TICK_DIV = 4;
  localparam int          CLK_P    = 10;
  localparam int          TICK_T   = TICK_DIV * CLK_P;
  localparam int          W0       = 8;    // '0' pulse, ticks
  localparam int          W1       = 18;   // '1' pulse, ticks
  localparam int          GAP_T    = 12;   // gap between seconds, ticks
  localparam int          MARK_T   = 180;  // minute-mark gap, ticks

  logic        clk_in  = 1'b0;
  logic        reset_n = 1'b0;
  logic        dcf_in  = 1'b0;
  logic [58:0] wb_tempbuffer;
  logic        sincro;
  logic        locked;
  logic        frame_error;
  logic [5:0]  bit_count;

  int          checks   = 0;
  int          failures = 0;
  int          n_sincro = 0;
  int          n_err    = 0;
  logic [58:0] exp_wb   = '0;
  logic [58:0] prev_wb  = '0;
  logic        prev_rst = 1'b0;
  logic        prev_sincro = 1'b0;

  dcf77_frame_decoder #(
    .TICK_DIV   (TICK_DIV),
    .MIN_PULSE  (5),
    .BIT_THRESH (15),
    .MAX_PULSE  (30),
    .GAP_MARK   (150),
    .MAX_GAP    (210)
  ) dut (
    .clk_in        (clk_in),
    .reset_n       (reset_n),
    .dcf_in        (dcf_in),
    .wb_tempbuffer (wb_tempbuffer),
    .sincro        (sincro),
    .locked        (locked),
    .frame_error   (frame_error),
    .bit_count     (bit_count)
  );

  always #(CLK_P/2) clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Event counters and invariants sampled on the falling edge
  always @(negedge clk_in) begin
    if (sincro) begin
      n_sincro++;
      chk("sincro_err_excl", 64'(frame_error), 64'd0);
      chk("sincro_one_cycle", 64'(prev_sincro), 64'd0);
    end
    if (frame_error) n_err++;
    if (reset_n && prev_rst && (wb_tempbuffer != prev_wb))
      chk("wb_only_on_sincro", 64'(sincro), 64'd1);
    prev_wb     = wb_tempbuffer;
    prev_rst    = reset_n;
    prev_sincro = sincro;
  end

  function automatic logic [58:0] fix_parity(input logic [58:0] fi);
    logic [58:0] f;
    f = fi;
    f[28] = ^f[27:21];
    f[35] = ^f[34:29];
    f[58] = ^f[57:36];
    return f;
  endfunction

  // BCD frame encoder with even parity per field
  function automatic logic [58:0] build_frame(input int mi, input int hr, input int dy, input int wd,
                                              input int mo, input int yr, input logic [18:0] misc);
    logic [58:0] f;
    f = '0;
    f[19:1]  = misc;
    f[20]    = 1'b1;
    f[24:21] = 4'(mi % 10);
    f[27:25] = 3'(mi / 10);
    f[32:29] = 4'(hr % 10);
    f[34:33] = 2'(hr / 10);
    f[39:36] = 4'(dy % 10);
    f[41:40] = 2'(dy / 10);
    f[44:42] = 3'(wd);
    f[48:45] = 4'(mo % 10);
    f[49]    = 1'(mo / 10);
    f[53:50] = 4'(yr % 10);
    f[57:54] = 4'(yr / 10);
    return fix_parity(f);
  endfunction

  function automatic logic [58:0] rand_frame();
    return build_frame(int'($urandom_range(0, 59)), int'($urandom_range(0, 23)),
                       int'($urandom_range(1, 31)), int'($urandom_range(1, 7)),
                       int'($urandom_range(1, 12)), int'($urandom_range(0, 99)),
                       19'($urandom));
  endfunction

  // Reference acceptance rule, expressed with counts of ones per field
  function automatic bit model_valid(input logic [58:0] f, input int nbits);
    int ones_m, ones_h, ones_d;
    ones_m = 0; ones_h = 0; ones_d = 0;
    if (nbits != 59) return 1'b0;
    if (f[0] != 1'b0 || f[20] != 1'b1) return 1'b0;
    for (int i = 21; i <= 28; i++) ones_m += int'(f[i]);
    for (int i = 29; i <= 35; i++) ones_h += int'(f[i]);
    for (int i = 36; i <= 58; i++) ones_d += int'(f[i]);
    if ((ones_m % 2) != 0 || (ones_h % 2) != 0 || (ones_d % 2) != 0) return 1'b0;
    if (int'(f[24:21]) > 9 || int'(f[32:29]) > 9) return 1'b0;
    return 1'b1;
  endfunction

  task automatic send_bits(input logic [58:0] f, input int first, input int last, input bit mark);
    int w;
    for (int i = first; i <= last; i++) begin
      w = f[i] ? W1 : W0;
      dcf_in = 1'b1;
      #(w * TICK_T);
      dcf_in = 1'b0;
      #(((mark && i == last) ? MARK_T : GAP_T) * TICK_T);
    end
  endtask

  // Drive the rise that ends a long gap (also second 0's '0' pulse) and check its outcome
  task automatic mark_expect(input string tag, input int exp_s, input int exp_e);
    int s0, e0;
    s0 = n_sincro;
    e0 = n_err;
    dcf_in = 1'b1;
    #(4 * TICK_T);
    chk({tag, "_bitcnt0"}, 64'(bit_count), 64'd0);
    #((W0 - 4) * TICK_T);
    dcf_in = 1'b0;
    #(GAP_T * TICK_T);
    chk({tag, "_sincro"}, 64'(n_sincro - s0), 64'(exp_s));
    chk({tag, "_ferr"}, 64'(n_err - e0), 64'(exp_e));
    chk({tag, "_wb"}, 64'(wb_tempbuffer), 64'(exp_wb));
  endtask

  initial begin
    logic [58:0] fa, fb, fr;
    bit          v;
    int          mode, idx, e0;

    #(5 * CLK_P);
    chk("rst_wb", 64'(wb_tempbuffer), 64'd0);
    chk("rst_sincro", 64'(sincro), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_ferr", 64'(frame_error), 64'd0);
    chk("rst_bitcnt", 64'(bit_count), 64'd0);
    #(5 * CLK_P);
    reset_n = 1'b1;

    // Signal absent: one loss report, nothing published
    #(300 * TICK_T);
    chk("lost_ferr", 64'(n_err), 64'd1);
    chk("lost_sincro", 64'(n_sincro), 64'd0);
    chk("lost_locked", 64'(locked), 64'd0);
    chk("lost_wb", 64'(wb_tempbuffer), 64'd0);

    // First mark only synchronises
    mark_expect("hunt_mark", 0, 0);

    // 14:37, Sat 15.06.24
    fa = build_frame(37, 14, 15, 6, 6, 24, 19'h0);
    send_bits(fa, 1, 58, 1'b1);
    chk("a_bitcnt59", 64'(bit_count), 64'd59);
    exp_wb = fa;
    mark_expect("a", 1, 0);
    chk("a_locked", 64'(locked), 64'd1);
    chk("a_min_units", 64'(wb_tempbuffer[24:21]), 64'd7);
    chk("a_min_tens", 64'(wb_tempbuffer[27:25]), 64'd3);
    chk("a_hr_units", 64'(wb_tempbuffer[32:29]), 64'd4);
    chk("a_hr_tens", 64'(wb_tempbuffer[34:33]), 64'd1);

    // Minute parity broken
    fb = fa;
    fb[28] = ~fb[28];
    send_bits(fb, 1, 58, 1'b1);
    mark_expect("b_parity", 0, 1);
    chk("b_locked", 64'(locked), 64'd0);

    // Random frames, some corrupted, judged by the model
    for (int k = 0; k < 2; k++) begin
      fr = rand_frame();
      mode = (k == 0) ? 0 : int'($urandom_range(1, 3));
      if (mode == 1) begin
        idx = int'($urandom_range(1, 58));
        fr[idx] = ~fr[idx];
      end else if (mode == 2) begin
        fr[24:21] = 4'($urandom_range(10, 15));
        fr = fix_parity(fr);
      end else if (mode == 3) begin
        fr[32:29] = 4'($urandom_range(10, 15));
        fr = fix_parity(fr);
      end
      v = model_valid(fr, 59);
      send_bits(fr, 1, 58, 1'b1);
      if (v) exp_wb = fr;
      mark_expect("rnd", v ? 1 : 0, v ? 0 : 1);
      chk("rnd_locked", 64'(locked), 64'(v));
    end

    // Short frame of 58 bits
    fr = rand_frame();
    v = model_valid(fr, 58);
    send_bits(fr, 1, 57, 1'b1);
    chk("short_bitcnt58", 64'(bit_count), 64'd58);
    mark_expect("short", v ? 1 : 0, v ? 0 : 1);
    chk("short_locked", 64'(locked), 64'(v));

    // Glitch mid-frame, then a mark from hunt, then a full frame
    fr = rand_frame();
    send_bits(fr, 1, 10, 1'b0);
    e0 = n_err;
    dcf_in = 1'b1;
    #(3 * TICK_T);
    dcf_in = 1'b0;
    #(GAP_T * TICK_T);
    chk("glitch_ferr", 64'(n_err - e0), 64'd1);
    send_bits(fr, 11, 58, 1'b1);
    mark_expect("post_glitch", 0, 0);
    fr = rand_frame();
    send_bits(fr, 1, 58, 1'b1);
    exp_wb = fr;
    mark_expect("recover", 1, 0);
    chk("recover_locked", 64'(locked), 64'd1);

    // Reset in the middle of a frame
    fr = rand_frame();
    send_bits(fr, 1, 30, 1'b0);
    reset_n = 1'b0;
    #(4 * CLK_P);
    reset_n = 1'b1;
    #(2 * CLK_P);
    exp_wb = '0;
    chk("mid_rst_bitcnt", 64'(bit_count), 64'd0);
    chk("mid_rst_wb", 64'(wb_tempbuffer), 64'd0);
    chk("mid_rst_locked", 64'(locked), 64'd0);
    send_bits(fr, 31, 58, 1'b1);
    mark_expect("post_reset", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
